// File: rtl/instr_encoder_if.sv
// Field/handshake and instruction-memory bundle for instr_encoder.
// master drives instruction fields; slave (the encoder) drives the memory side.
interface instr_encoder_if #(
   parameter int unsigned AW = 6
);
   logic          in_valid;
   logic          in_ready;
   logic [1:0]    fmt;
   logic [5:0]    op;
   logic [4:0]    rs;
   logic [4:0]    rt;
   logic [4:0]    rd;
   logic [4:0]    shamt;
   logic [5:0]    funct;
   logic [15:0]   imm;
   logic [25:0]   target;
   logic          last;
   logic          imem_we;
   logic [AW-1:0] imem_addr;
   logic [31:0]   imem_wd;
   logic [AW:0]   count;
   logic          done;
   logic          err;

   modport master (
      output in_valid, fmt, op, rs, rt, rd, shamt, funct, imm, target, last,
      input  in_ready, imem_we, imem_addr, imem_wd, count, done, err
   );

   modport slave (
      input  in_valid, fmt, op, rs, rt, rd, shamt, funct, imm, target, last,
      output in_ready, imem_we, imem_addr, imem_wd, count, done, err
   );
endinterface

// File: rtl/instr_encoder.sv
// Encodes R/I/J instruction fields into 32-bit words and loads them into instruction memory.
// Optional field checking is enabled by defining INSTR_ENCODER_CHECK_EN.
module instr_encoder #(
   parameter int unsigned DEPTH = 64,
   parameter int unsigned AW    = 6
) (
   input logic              clk,
   input logic              reset,
   instr_encoder_if.slave   bus
);

   localparam logic [AW:0] DepthCnt = (AW+1)'(DEPTH);

   typedef enum logic [1:0] {StIdle, StWrite, StDone} state_e;

   state_e        state_q, state_d;
   logic [31:0]   wd_q, wd_d;
   logic [AW-1:0] addr_q, addr_d;
   logic [AW:0]   count_q, count_d;
   logic          last_q, last_d;
   logic [31:0]   enc_word;
   logic [AW:0]   count_inc;
   logic          xfer;
   logic          reject;
   logic          err_set;

   assign xfer      = bus.in_valid && (state_q == StIdle);
   assign count_inc = count_q + (AW+1)'(1);

   // fmt=11 falls through to J layout; it is only reachable when checking is off.
   always_comb begin
      case (bus.fmt)
         2'b00:   enc_word = {bus.op, bus.rs, bus.rt, bus.rd, bus.shamt, bus.funct};
         2'b01:   enc_word = {bus.op, bus.rs, bus.rt, bus.imm};
         default: enc_word = {bus.op, bus.target};
      endcase
   end

`ifdef INSTR_ENCODER_CHECK_EN
   logic err_q, err_d;

   always_comb begin
      case (bus.fmt)
         2'b00:   reject = (bus.op != 6'd0);
         2'b01:   reject = (bus.op == 6'd0) || (bus.op == 6'd2) || (bus.op == 6'd3);
         2'b10:   reject = !((bus.op == 6'd2) || (bus.op == 6'd3));
         default: reject = 1'b1;
      endcase
   end

   assign err_d = err_q | err_set;

   always_ff @(posedge clk) begin
      if (reset) begin
         err_q <= 1'b0;
      end else begin
         err_q <= err_d;
      end
   end

   assign bus.err = err_q;
`else
   assign reject  = 1'b0;
   assign bus.err = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      wd_d    = wd_q;
      addr_d  = addr_q;
      count_d = count_q;
      last_d  = last_q;
      err_set = 1'b0;
      case (state_q)
         StIdle: begin
            if (xfer) begin
               if (reject) begin
                  err_set = 1'b1;
                  if (bus.last) begin
                     state_d = StDone;
                  end
               end else begin
                  wd_d    = enc_word;
                  addr_d  = count_q[AW-1:0];
                  last_d  = bus.last;
                  state_d = StWrite;
               end
            end
         end
         StWrite: begin
            count_d = count_inc;
            // Stop at DEPTH rather than wrap the address.
            if (last_q || (count_inc == DepthCnt)) begin
               state_d = StDone;
            end else begin
               state_d = StIdle;
            end
         end
         StDone: begin
            state_d = StDone;
         end
         default: begin
            state_d = StIdle;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= StIdle;
         wd_q    <= '0;
         addr_q  <= '0;
         count_q <= '0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         addr_q  <= addr_d;
         count_q <= count_d;
         last_q  <= last_d;
      end
   end

   assign bus.in_ready  = (state_q == StIdle);
   assign bus.imem_we   = (state_q == StWrite);
   assign bus.done      = (state_q == StDone);
   assign bus.imem_wd   = wd_q;
   assign bus.imem_addr = addr_q;
   assign bus.count     = count_q;

endmodule

// File: tb/tb_instr_encoder.sv
// Directed self-checking bench for instr_encoder: a DEPTH=64 instance for encoding,
// handshake and reset behaviour, and a DEPTH=4 instance for the no-wrap limit.
module tb_instr_encoder;

   logic clk;
   logic reset;
   int   n_tests;
   int   n_fail;
   int   nwr;

   instr_encoder_if #(.AW(6)) bus_a ();
   instr_encoder_if #(.AW(2)) bus_b ();

   instr_encoder #(.DEPTH(64), .AW(6)) u_dut_a (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_a)
   );

   instr_encoder #(.DEPTH(4), .AW(2)) u_dut_b (
      .clk   (clk),
      .reset (reset),
      .bus   (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_a(input logic v, input logic [1:0] f, input logic [5:0] o,
                          input logic [4:0] s, input logic [4:0] t, input logic [4:0] d,
                          input logic [4:0] sh, input logic [5:0] fn, input logic [15:0] im,
                          input logic [25:0] tg, input logic l);
      bus_a.in_valid = v;
      bus_a.fmt      = f;
      bus_a.op       = o;
      bus_a.rs       = s;
      bus_a.rt       = t;
      bus_a.rd       = d;
      bus_a.shamt    = sh;
      bus_a.funct    = fn;
      bus_a.imm      = im;
      bus_a.target   = tg;
      bus_a.last     = l;
   endtask

`ifdef INSTR_ENCODER_CHECK_EN
   localparam int unsigned JAddr  = 3;
`else
   localparam int unsigned JAddr  = 4;
`endif

   initial begin
      n_tests = 0;
      n_fail  = 0;
      reset   = 1'b1;
      drive_a(1'b0, 2'b00, 6'd0, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b0);
      bus_b.in_valid = 1'b0;
      bus_b.fmt      = 2'b01;
      bus_b.op       = 6'h08;
      bus_b.rs       = 5'd1;
      bus_b.rt       = 5'd2;
      bus_b.rd       = 5'd0;
      bus_b.shamt    = 5'd0;
      bus_b.funct    = 6'd0;
      bus_b.imm      = 16'h1234;
      bus_b.target   = 26'd0;
      bus_b.last     = 1'b0;
      step();
      step();
      reset = 1'b0;

      check_eq("rst_count", 32'(bus_a.count), 32'd0);
      check_eq("rst_addr", 32'(bus_a.imem_addr), 32'd0);
      check_eq("rst_wd", bus_a.imem_wd, 32'd0);
      check_eq("rst_we", 32'(bus_a.imem_we), 32'd0);
      check_eq("rst_done", 32'(bus_a.done), 32'd0);
      check_eq("rst_err", 32'(bus_a.err), 32'd0);
      check_eq("rst_ready", 32'(bus_a.in_ready), 32'd1);

      // R: add $16,$17,$18
      drive_a(1'b1, 2'b00, 6'd0, 5'd17, 5'd18, 5'd16, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
      step();
      bus_a.in_valid = 1'b0;
      check_eq("r_we", 32'(bus_a.imem_we), 32'd1);
      check_eq("r_addr", 32'(bus_a.imem_addr), 32'd0);
      check_eq("r_wd", bus_a.imem_wd, 32'h02328020);
      check_eq("r_ready", 32'(bus_a.in_ready), 32'd0);
      step();
      check_eq("r_we_off", 32'(bus_a.imem_we), 32'd0);
      check_eq("r_count", 32'(bus_a.count), 32'd1);
      check_eq("r_wd_hold", bus_a.imem_wd, 32'h02328020);
      check_eq("r_addr_hold", 32'(bus_a.imem_addr), 32'd0);

      // I: lw $8,4($0)
      drive_a(1'b1, 2'b01, 6'h23, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
      step();
      bus_a.in_valid = 1'b0;
      check_eq("i_wd", bus_a.imem_wd, 32'h8C080004);
      check_eq("i_addr", 32'(bus_a.imem_addr), 32'd1);
      step();

      // R with shamt: sll $10,$9,3
      drive_a(1'b1, 2'b00, 6'd0, 5'd0, 5'd9, 5'd10, 5'd3, 6'h00, 16'd0, 26'd0, 1'b0);
      step();
      bus_a.in_valid = 1'b0;
      check_eq("sh_wd", bus_a.imem_wd, 32'h000950C0);
      check_eq("sh_addr", 32'(bus_a.imem_addr), 32'd2);
      step();
      check_eq("sh_count", 32'(bus_a.count), 32'd3);

`ifdef INSTR_ENCODER_CHECK_EN
      // R format with nonzero op is rejected.
      drive_a(1'b1, 2'b00, 6'h23, 5'd1, 5'd2, 5'd3, 5'd0, 6'h20, 16'd0, 26'd0, 1'b0);
      step();
      bus_a.in_valid = 1'b0;
      check_eq("rej_we", 32'(bus_a.imem_we), 32'd0);
      check_eq("rej_err", 32'(bus_a.err), 32'd1);
      check_eq("rej_ready", 32'(bus_a.in_ready), 32'd1);
      check_eq("rej_count", 32'(bus_a.count), 32'd3);
      check_eq("rej_wd_hold", bus_a.imem_wd, 32'h000950C0);
      // Reserved format rejected.
      drive_a(1'b1, 2'b11, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h155, 1'b0);
      step();
      bus_a.in_valid = 1'b0;
      check_eq("rej11_we", 32'(bus_a.imem_we), 32'd0);
      check_eq("rej11_count", 32'(bus_a.count), 32'd3);
`else
      // Reserved format encodes as J when unchecked.
      drive_a(1'b1, 2'b11, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h155, 1'b0);
      step();
      bus_a.in_valid = 1'b0;
      check_eq("f11_we", 32'(bus_a.imem_we), 32'd1);
      check_eq("f11_wd", bus_a.imem_wd, 32'h08000155);
      check_eq("f11_addr", 32'(bus_a.imem_addr), 32'd3);
      step();
      check_eq("f11_err", 32'(bus_a.err), 32'd0);
`endif

      // J: j 0x10, last
      drive_a(1'b1, 2'b10, 6'd2, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'h10, 1'b1);
      step();
      check_eq("j_we", 32'(bus_a.imem_we), 32'd1);
      check_eq("j_wd", bus_a.imem_wd, 32'h08000010);
      check_eq("j_addr", 32'(bus_a.imem_addr), JAddr);
      // Keep offering words; DONE must ignore them.
      for (int i = 0; i < 12; i++) begin
         step();
         check_eq("j_done", 32'(bus_a.done), 32'd1);
         check_eq("j_ready", 32'(bus_a.in_ready), 32'd0);
         check_eq("j_we_off", 32'(bus_a.imem_we), 32'd0);
      end
      check_eq("j_count", 32'(bus_a.count), JAddr + 1);

      // Reset in a WRITE cycle discards the word.
      reset = 1'b1;
      bus_a.in_valid = 1'b0;
      step();
      reset = 1'b0;
      drive_a(1'b1, 2'b01, 6'h23, 5'd0, 5'd8, 5'd0, 5'd0, 6'd0, 16'd4, 26'd0, 1'b0);
      step();
      bus_a.in_valid = 1'b0;
      check_eq("rw_we", 32'(bus_a.imem_we), 32'd1);
      reset = 1'b1;
      step();
      check_eq("rw_we_off", 32'(bus_a.imem_we), 32'd0);
      check_eq("rw_count", 32'(bus_a.count), 32'd0);
      check_eq("rw_ready", 32'(bus_a.in_ready), 32'd1);
      check_eq("rw_done", 32'(bus_a.done), 32'd0);
      reset = 1'b0;
      step();
      check_eq("rw_count2", 32'(bus_a.count), 32'd0);

`ifdef INSTR_ENCODER_CHECK_EN
      // Rejected last word goes straight to DONE without a write.
      drive_a(1'b1, 2'b00, 6'h23, 5'd0, 5'd0, 5'd0, 5'd0, 6'd0, 16'd0, 26'd0, 1'b1);
      step();
      bus_a.in_valid = 1'b0;
      check_eq("rl_done", 32'(bus_a.done), 32'd1);
      check_eq("rl_we", 32'(bus_a.imem_we), 32'd0);
      check_eq("rl_count", 32'(bus_a.count), 32'd0);
      check_eq("rl_err", 32'(bus_a.err), 32'd1);
`endif

      // DEPTH=4 with in_valid held: four writes then DONE, no wrap.
      nwr = 0;
      bus_b.in_valid = 1'b1;
      for (int i = 0; i < 20; i++) begin
         step();
         if (bus_b.imem_we) begin
            check_eq("b_addr", 32'(bus_b.imem_addr), nwr);
            check_eq("b_wd", bus_b.imem_wd, 32'h20221234);
            nwr++;
         end
      end
      check_eq("b_nwrites", nwr, 32'd4);
      check_eq("b_count", 32'(bus_b.count), 32'd4);
      check_eq("b_done", 32'(bus_b.done), 32'd1);
      check_eq("b_ready", 32'(bus_b.in_ready), 32'd0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
